// File: rtl/apple_ctrl.sv
// rtl/apple_ctrl.sv - apple placement, eat detection, scoring and apple pixel flag
// Candidates are vetted by an external body checker; the 8th candidate is placed regardless of the result.
module apple_ctrl (
   input  logic       VGA_clk,
   input  logic       reset,
   input  logic [9:0] rand_X,
   input  logic [9:0] rand_Y,
   input  logic [9:0] head_X,
   input  logic [9:0] head_Y,
   input  logic       game_tick,
   input  logic       chk_ack,
   input  logic       chk_hit,
   input  logic [9:0] xCount,
   input  logic [9:0] yCount,
   output logic       chk_req,
   output logic [9:0] chk_X,
   output logic [9:0] chk_Y,
   output logic [9:0] apple_X,
   output logic [9:0] apple_Y,
   output logic       apple_valid,
   output logic       grow,
   output logic [7:0] score,
   output logic       apple_pix
);

   typedef enum logic [1:0] {SAMPLE, CHECK, ACTIVE} state_t;

   state_t     state_q, state_d;
   logic       chk_req_q, chk_req_d;
   logic [9:0] chk_x_q, chk_x_d;
   logic [9:0] chk_y_q, chk_y_d;
   logic [9:0] apple_x_q, apple_x_d;
   logic [9:0] apple_y_q, apple_y_d;
   logic       apple_valid_q, apple_valid_d;
   logic       grow_q, grow_d;
   logic [7:0] score_q, score_d;
   logic [2:0] attempt_q, attempt_d;
   logic       apple_pix_q, apple_pix_d;

   logic        rejected;
   logic        eat;
   logic [10:0] px, py, ax, ay;

   assign rejected = chk_hit || ((chk_x_q == head_X) && (chk_y_q == head_Y));
   assign eat      = game_tick && (head_X == apple_x_q) && (head_Y == apple_y_q);

   // Widened so that apple_X + 10 near the right/bottom edge cannot wrap
   assign px = {1'b0, xCount};
   assign py = {1'b0, yCount};
   assign ax = {1'b0, apple_x_q};
   assign ay = {1'b0, apple_y_q};

   always_comb begin
      state_d       = state_q;
      chk_req_d     = chk_req_q;
      chk_x_d       = chk_x_q;
      chk_y_d       = chk_y_q;
      apple_x_d     = apple_x_q;
      apple_y_d     = apple_y_q;
      apple_valid_d = apple_valid_q;
      grow_d        = 1'b0;
      score_d       = score_q;
      attempt_d     = attempt_q;
      apple_pix_d   = apple_valid_q && (px >= ax) && (px < ax + 11'd10)
                                    && (py >= ay) && (py < ay + 11'd10);
      case (state_q)
         SAMPLE: begin
            chk_x_d   = rand_X;
            chk_y_d   = rand_Y;
            chk_req_d = 1'b1;
            state_d   = CHECK;
         end
         CHECK: begin
            if (chk_ack) begin
               chk_req_d = 1'b0;
               // attempt_q counts rejections so far; 7 means this is the 8th try
               if (rejected && (attempt_q != 3'd7)) begin
                  attempt_d = attempt_q + 3'd1;
                  state_d   = SAMPLE;
               end else begin
                  apple_x_d     = chk_x_q;
                  apple_y_d     = chk_y_q;
                  apple_valid_d = 1'b1;
                  attempt_d     = 3'd0;
                  state_d       = ACTIVE;
               end
            end
         end
         ACTIVE: begin
            if (eat) begin
               grow_d        = 1'b1;
               apple_valid_d = 1'b0;
               state_d       = SAMPLE;
               if (score_q != 8'hFF) begin
                  score_d = score_q + 8'd1;
               end
            end
         end
         default: state_d = SAMPLE;
      endcase
   end

   always_ff @(posedge VGA_clk) begin
      if (!reset) begin
         state_q       <= SAMPLE;
         chk_req_q     <= 1'b0;
         chk_x_q       <= 10'd0;
         chk_y_q       <= 10'd0;
         apple_x_q     <= 10'd0;
         apple_y_q     <= 10'd0;
         apple_valid_q <= 1'b0;
         grow_q        <= 1'b0;
         score_q       <= 8'd0;
         attempt_q     <= 3'd0;
         apple_pix_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         chk_req_q     <= chk_req_d;
         chk_x_q       <= chk_x_d;
         chk_y_q       <= chk_y_d;
         apple_x_q     <= apple_x_d;
         apple_y_q     <= apple_y_d;
         apple_valid_q <= apple_valid_d;
         grow_q        <= grow_d;
         score_q       <= score_d;
         attempt_q     <= attempt_d;
         apple_pix_q   <= apple_pix_d;
      end
   end

   assign chk_req     = chk_req_q;
   assign chk_X       = chk_x_q;
   assign chk_Y       = chk_y_q;
   assign apple_X     = apple_x_q;
   assign apple_Y     = apple_y_q;
   assign apple_valid = apple_valid_q;
   assign grow        = grow_q;
   assign score       = score_q;
   assign apple_pix   = apple_pix_q;

endmodule

// File: tb/tb_apple_ctrl.sv
// tb/tb_apple_ctrl.sv - self-checking bench for apple_ctrl
// Transaction-level reference model compared every cycle, plus directed literal checks.
module tb_apple_ctrl;

   logic       VGA_clk = 1'b0;
   logic       reset;
   logic [9:0] rand_X, rand_Y, head_X, head_Y, xCount, yCount;
   logic       game_tick, chk_ack, chk_hit;
   logic       chk_req, apple_valid, grow, apple_pix;
   logic [9:0] chk_X, chk_Y, apple_X, apple_Y;
   logic [7:0] score;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   always #5 VGA_clk = ~VGA_clk;

   apple_ctrl dut (
      .VGA_clk(VGA_clk), .reset(reset),
      .rand_X(rand_X), .rand_Y(rand_Y), .head_X(head_X), .head_Y(head_Y),
      .game_tick(game_tick), .chk_ack(chk_ack), .chk_hit(chk_hit),
      .xCount(xCount), .yCount(yCount),
      .chk_req(chk_req), .chk_X(chk_X), .chk_Y(chk_Y),
      .apple_X(apple_X), .apple_Y(apple_Y), .apple_valid(apple_valid),
      .grow(grow), .score(score), .apple_pix(apple_pix)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference model: phase 0 = about to draw a candidate, 1 = query outstanding, 2 = apple live
   int m_phase = 0, m_cx = 0, m_cy = 0, m_ax = 0, m_ay = 0, m_score = 0, m_tries = 0;
   bit m_req = 0, m_valid = 0, m_grow = 0, m_pix = 0;

   always @(posedge VGA_clk) begin
      m_grow <= 1'b0;
      m_pix  <= m_valid && int'(xCount) >= m_ax && int'(xCount) < m_ax + 10
                        && int'(yCount) >= m_ay && int'(yCount) < m_ay + 10;
      if (!reset) begin
         m_phase <= 0; m_req <= 0; m_cx <= 0; m_cy <= 0; m_ax <= 0; m_ay <= 0;
         m_valid <= 0; m_score <= 0; m_tries <= 0; m_pix <= 0;
      end else if (m_phase == 0) begin
         m_cx <= int'(rand_X);
         m_cy <= int'(rand_Y);
         m_req <= 1;
         m_phase <= 1;
      end else if (m_phase == 1) begin
         if (chk_ack) begin
            m_req <= 0;
            if ((chk_hit || (m_cx == int'(head_X) && m_cy == int'(head_Y))) && m_tries + 1 < 8) begin
               m_tries <= m_tries + 1;
               m_phase <= 0;
            end else begin
               m_ax <= m_cx; m_ay <= m_cy; m_valid <= 1; m_tries <= 0; m_phase <= 2;
            end
         end
      end else if (game_tick && int'(head_X) == m_ax && int'(head_Y) == m_ay) begin
         m_grow  <= 1;
         m_score <= (m_score < 255) ? m_score + 1 : 255;
         m_valid <= 0;
         m_phase <= 0;
      end
   end

   always @(negedge VGA_clk) begin
      if (cmp_en) begin
         chk("chk_req", chk_req, m_req);
         if (m_req) begin
            chk("chk_X", chk_X, m_cx);
            chk("chk_Y", chk_Y, m_cy);
         end
         chk("apple_valid", apple_valid, m_valid);
         if (m_valid) begin
            chk("apple_X", apple_X, m_ax);
            chk("apple_Y", apple_Y, m_ay);
         end
         chk("grow", grow, m_grow);
         chk("score", score, m_score);
         chk("apple_pix", apple_pix, m_pix);
      end
   end

   task automatic answer(input logic hit, input int lat);
      int n = 0;
      while (chk_req !== 1'b1 && n < 50) begin
         @(negedge VGA_clk);
         n++;
      end
      chk("req_wait", int'(n < 50), 1);
      repeat (lat) @(negedge VGA_clk);
      chk_ack = 1'b1;
      chk_hit = hit;
      @(negedge VGA_clk);
      chk_ack = 1'b0;
      chk_hit = 1'b0;
   endtask

   task automatic eat_at(input int x, input int y);
      head_X = 10'(x);
      head_Y = 10'(y);
      game_tick = 1'b1;
      @(negedge VGA_clk);
      game_tick = 1'b0;
      head_X = 10'd0;
      head_Y = 10'd0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int ex, ey;
      reset = 1'b0; rand_X = 10'd200; rand_Y = 10'd100;
      head_X = 10'd0; head_Y = 10'd0; game_tick = 1'b0;
      chk_ack = 1'b0; chk_hit = 1'b0; xCount = 10'd0; yCount = 10'd0;
      repeat (3) @(negedge VGA_clk);
      cmp_en = 1'b1;
      chk("rst_req", chk_req, 0);
      chk("rst_valid", apple_valid, 0);
      chk("rst_score", score, 0);
      chk("rst_chk_x", chk_X, 0);

      // Scenario 1: first placement
      reset = 1'b1;
      answer(1'b0, 1);
      chk("s1_apple_x", apple_X, 200);
      chk("s1_apple_y", apple_Y, 100);
      chk("s1_valid", apple_valid, 1);
      chk("s1_req_low", chk_req, 0);

      // Scenario 2: eat
      eat_at(200, 100);
      chk("s2_grow", grow, 1);
      chk("s2_score", score, 1);
      chk("s2_valid", apple_valid, 0);
      @(negedge VGA_clk);
      chk("s2_grow_once", grow, 0);
      chk("s2_req", chk_req, 1);
      head_X = 10'd200; head_Y = 10'd100; game_tick = 1'b1;
      @(negedge VGA_clk);
      game_tick = 1'b0; head_X = 10'd0; head_Y = 10'd0;
      chk("s2_tick_ignored_grow", grow, 0);
      chk("s2_tick_ignored_score", score, 1);

      // Scenario 3a: 7 hits then a clean 8th candidate
      for (int i = 0; i < 8; i++) begin
         answer(i < 7 ? 1'b1 : 1'b0, i % 3);
         if (i == 6) begin
            rand_X = 10'd620; rand_Y = 10'd460;
         end else begin
            rand_X = 10'(30 + 10 * i); rand_Y = 10'd50;
         end
         if (i < 7) chk("s3_not_placed", apple_valid, 0);
      end
      chk("s3a_apple_x", apple_X, 620);
      chk("s3a_apple_y", apple_Y, 460);
      chk("s3a_valid", apple_valid, 1);

      chk_ack = 1'b1; rand_X = 10'd20; rand_Y = 10'd20;
      @(negedge VGA_clk);
      chk_ack = 1'b0;
      chk("ack_ignored_x", apple_X, 620);
      chk("ack_ignored_req", chk_req, 0);

      // Scenario 5: pixel flag at the far corner
      xCount = 10'd629; yCount = 10'd469; @(negedge VGA_clk);
      chk("s5_pix_corner", apple_pix, 1);
      xCount = 10'd630; @(negedge VGA_clk);
      chk("s5_pix_right", apple_pix, 0);
      xCount = 10'd620; yCount = 10'd460; @(negedge VGA_clk);
      chk("s5_pix_origin", apple_pix, 1);
      xCount = 10'd619; yCount = 10'd465; @(negedge VGA_clk);
      chk("s5_pix_left", apple_pix, 0);
      xCount = 10'd0; yCount = 10'd0;

      // Scenario 3b: all 8 candidates hit, 8th still placed
      rand_X = 10'd300; rand_Y = 10'd200;
      eat_at(620, 460);
      for (int i = 0; i < 8; i++) begin
         answer(1'b1, 0);
         if (i == 6) begin
            rand_X = 10'd440; rand_Y = 10'd300;
         end else begin
            rand_X = 10'(30 + 10 * i); rand_Y = 10'd40;
         end
      end
      chk("s3b_apple_x", apple_X, 440);
      chk("s3b_apple_y", apple_Y, 300);
      chk("s3b_score", score, 2);

      // Scenario 4: candidate on the head is rejected
      rand_X = 10'd100; rand_Y = 10'd200;
      eat_at(440, 300);
      head_X = 10'd100; head_Y = 10'd200;
      answer(1'b0, 0);
      chk("s4_head_reject", apple_valid, 0);
      rand_X = 10'd120; rand_Y = 10'd200;
      answer(1'b0, 0);
      head_X = 10'd0; head_Y = 10'd0;
      chk("s4_apple_x", apple_X, 120);
      chk("s4_valid", apple_valid, 1);

      // Score saturation
      rand_X = 10'd40; rand_Y = 10'd40;
      ex = 120; ey = 200;
      for (int k = 0; k < 253; k++) begin
         eat_at(ex, ey);
         answer(1'b0, 0);
         ex = 40; ey = 40;
      end
      chk("sat_score", score, 255);
      eat_at(40, 40);
      chk("sat_grow", grow, 1);
      chk("sat_score_hold", score, 255);
      answer(1'b0, 0);

      // Scenario 6: reset mid-CHECK, then reset in an eat cycle
      eat_at(40, 40);
      @(negedge VGA_clk);
      chk("s6_in_check", chk_req, 1);
      rand_X = 10'd60; rand_Y = 10'd60;
      reset = 1'b0; chk_ack = 1'b1;
      @(negedge VGA_clk);
      reset = 1'b1; chk_ack = 1'b0;
      chk("s6_req", chk_req, 0);
      chk("s6_valid", apple_valid, 0);
      chk("s6_apple_x", apple_X, 0);
      chk("s6_chk_x", chk_X, 0);
      chk("s6_score", score, 0);
      answer(1'b0, 0);
      chk("s6_replaced_x", apple_X, 60);
      head_X = 10'd60; head_Y = 10'd60; game_tick = 1'b1; reset = 1'b0;
      @(negedge VGA_clk);
      game_tick = 1'b0; reset = 1'b1; head_X = 10'd0; head_Y = 10'd0;
      chk("s6_eat_grow", grow, 0);
      chk("s6_eat_score", score, 0);
      chk("s6_eat_valid", apple_valid, 0);
      answer(1'b0, 0);
      repeat (3) @(negedge VGA_clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
